// File: rtl/pipeline_subtractor.sv
// rtl/pipeline_subtractor.sv - 32-bit four-stage byte-sliced pipelined subtractor
//
// Purpose: computes d = a - b - bi (mod 2^32) one byte per stage, with
// borrow-out bo and optional signed overflow ovf. Latency 4 edges including
// capture, one operation per cycle, whole-pipeline stall on back-pressure.
//
// Optional feature: define PIPE_SUB_OVF_EN to compute ovf; otherwise ovf = 0.
//
// Ports:
//   clk        input   1   clock, rising edge
//   rst_n      input   1   asynchronous active-low reset
//   in_valid   input   1   a, b, bi carry an operation
//   in_ready   output  1   operation accepted this cycle (= advance enable)
//   a          input  32   minuend
//   b          input  32   subtrahend
//   bi         input   1   borrow in
//   out_valid  output  1   d, bo, ovf hold a completed result
//   out_ready  input   1   consumer takes the result this cycle
//   d          output 32   difference
//   bo         output  1   borrow out
//   ovf        output  1   signed overflow (0 unless PIPE_SUB_OVF_EN)

module pipeline_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        bi,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] d,
  output logic        bo,
  output logic        ovf
);

  // Stage 1: byte 0 result, carry into byte 1, a/b bytes 3..1
  logic        v1_q;
  logic [7:0]  s1_q;
  logic        c1_q;
  logic [23:0] a1_q, b1_q;
  // Stage 2: bytes 1..0 result, carry into byte 2, a/b bytes 3..2
  logic        v2_q;
  logic [15:0] s2_q;
  logic        c2_q;
  logic [15:0] a2_q, b2_q;
  // Stage 3: bytes 2..0 result, carry into byte 3, a/b byte 3 (holds sign bits)
  logic        v3_q;
  logic [23:0] s3_q;
  logic        c3_q;
  logic [7:0]  a3_q, b3_q;
  // Stage 4: output registers
  logic        v4_q;
  logic [31:0] d_q;
  logic        bo_q;

  logic        en;

  // Subtraction as a + ~b + carry; carry into byte 0 is the inverted borrow.
  logic [8:0]  byte0_d, byte1_d, byte2_d, byte3_d;

  assign byte0_d = {1'b0, a[7:0]}    + {1'b0, ~b[7:0]}    + {8'd0, ~bi};
  assign byte1_d = {1'b0, a1_q[7:0]} + {1'b0, ~b1_q[7:0]} + {8'd0, c1_q};
  assign byte2_d = {1'b0, a2_q[7:0]} + {1'b0, ~b2_q[7:0]} + {8'd0, c2_q};
  assign byte3_d = {1'b0, a3_q}      + {1'b0, ~b3_q}      + {8'd0, c3_q};

  // The whole pipe moves only when the output slot is free or being drained.
  assign en       = ~v4_q | out_ready;
  assign in_ready = en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0; s1_q <= '0; c1_q <= 1'b0; a1_q <= '0; b1_q <= '0;
      v2_q <= 1'b0; s2_q <= '0; c2_q <= 1'b0; a2_q <= '0; b2_q <= '0;
      v3_q <= 1'b0; s3_q <= '0; c3_q <= 1'b0; a3_q <= '0; b3_q <= '0;
      v4_q <= 1'b0; d_q  <= '0; bo_q <= 1'b0;
    end else if (en) begin
      // in_valid with en=1 is exactly an accepted operation; otherwise a bubble.
      v1_q <= in_valid;
      s1_q <= byte0_d[7:0];
      c1_q <= byte0_d[8];
      a1_q <= a[31:8];
      b1_q <= b[31:8];

      v2_q <= v1_q;
      s2_q <= {byte1_d[7:0], s1_q};
      c2_q <= byte1_d[8];
      a2_q <= a1_q[23:8];
      b2_q <= b1_q[23:8];

      v3_q <= v2_q;
      s3_q <= {byte2_d[7:0], s2_q};
      c3_q <= byte2_d[8];
      a3_q <= a2_q[15:8];
      b3_q <= b2_q[15:8];

      v4_q <= v3_q;
      d_q  <= {byte3_d[7:0], s3_q};
      bo_q <= ~byte3_d[8];
    end
  end

`ifdef PIPE_SUB_OVF_EN
  logic ovf_q;
  logic ovf_d;

  // Signs differ and the result sign departs from the minuend sign.
  assign ovf_d = (a3_q[7] != b3_q[7]) && (byte3_d[7] != a3_q[7]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = v4_q;
  assign d         = d_q;
  assign bo        = bo_q;

endmodule

// File: tb/tb_pipeline_subtractor.sv
// tb/tb_pipeline_subtractor.sv - self-checking bench for pipeline_subtractor

module tb_pipeline_subtractor;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        bi;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] d;
  logic        bo;
  logic        ovf;

  pipeline_subtractor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        bi;
    logic [31:0] d;
    logic        bo;
    logic        ovf;
  } vec_t;

  res_t sb[$];
  res_t cur_exp;
  int   compared   = 0;
  int   mismatched = 0;
  logic rnd_ready  = 1'b0;

  `ifdef PIPE_SUB_OVF_EN
  localparam bit OVF_ON = 1'b1;
  `else
  localparam bit OVF_ON = 1'b0;
  `endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb, input logic mbi);
    res_t r;
    logic [32:0] full;
    full  = {1'b0, ma} - {1'b0, mb} - {32'd0, mbi};
    r.d   = full[31:0];
    r.bo  = full[32];
    r.ovf = OVF_ON && (ma[31] != mb[31]) && (r.d[31] != ma[31]);
    return r;
  endfunction

  // Handshakes are observed mid-cycle: what is seen here is what the next edge does.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) sb.push_back(cur_exp);
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_output: got d=0x%08h expected no result", d);
      end else begin
        res_t e;
        e = sb.pop_front();
        chk("sb_d",   d,          e.d);
        chk("sb_bo",  {31'd0, bo},  {31'd0, e.bo});
        chk("sb_ovf", {31'd0, ovf}, {31'd0, e.ovf});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Called right after a posedge; returns right after the accepting posedge.
  task automatic send(input logic [31:0] sa, input logic [31:0] sbv, input logic sbi, input res_t e);
    bit ok;
    int guard;
    a = sa; b = sbv; bi = sbi; cur_exp = e; in_valid = 1'b1;
    ok = 1'b0;
    guard = 0;
    while (!ok && guard < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got in_ready=0 expected acceptance within 200 cycles");
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0, 1'b0};
    vecs[1] = '{32'h01000000, 32'h00000001, 1'b0, 32'h00FFFFFF, 1'b0, 1'b0};
    vecs[2] = '{32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[3] = '{32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[7] = '{32'h00000100, 32'h00000001, 1'b1, 32'h000000FE, 1'b0, 1'b0};
    vecs[8] = '{32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; bi = 1'b0; out_ready = 1'b1;
    cur_exp = '{32'd0, 1'b0, 1'b0};
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_d",         d, 0);
    chk("rst_bo",        {31'd0, bo}, 0);
    chk("rst_ovf",       {31'd0, ovf}, 0);
    chk("rst_in_ready",  {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: accepted on E0, visible only after E3.
    a = 32'd5; b = 32'd3; bi = 1'b0; cur_exp = '{32'd2, 1'b0, 1'b0}; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("lat_early_valid", {31'd0, out_valid}, 0);
    end
    @(negedge clk);
    chk("lat_valid", {31'd0, out_valid}, 1);
    chk("lat_d",     d, 32'd2);
    @(posedge clk); #1;

    // Table vectors, back to back.
    for (int i = 0; i < 9; i++) begin
      res_t e;
      e.d = vecs[i].d; e.bo = vecs[i].bo; e.ovf = OVF_ON && vecs[i].ovf;
      send(vecs[i].a, vecs[i].b, vecs[i].bi, e);
    end
    drain();

    // Random operands under random back-pressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra, rb;
      logic rbi;
      ra = $urandom; rb = $urandom; rbi = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ra;
      send(ra, rb, rbi, model(ra, rb, rbi));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rnd_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    // Six back-to-back ops with a multi-cycle stall at the output.
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          logic [31:0] ra;
          ra = 32'h1000_0000 * (i + 1) + 32'h0000_00FF;
          send(ra, 32'h0000_0100, 1'b0, model(ra, 32'h0000_0100, 1'b0));
        end
      end
      begin
        int guard;
        logic [31:0] d_hold;
        logic bo_hold;
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!out_valid && guard < 50);
        chk("stall_seen_valid", {31'd0, out_valid}, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        d_hold = d; bo_hold = bo;
        repeat (5) begin
          chk("stall_valid",    {31'd0, out_valid}, 1);
          chk("stall_in_ready", {31'd0, in_ready}, 0);
          chk("stall_d",        d, d_hold);
          chk("stall_bo",       {31'd0, bo}, {31'd0, bo_hold});
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      send(32'hA0 + i, 32'h1, 1'b0, model(32'hA0 + i, 32'h1, 1'b0));
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 0);
    chk("flush_d",         d, 0);
    sb.delete();
    #2;
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("flush_no_output", {31'd0, out_valid}, 0);
    end
    @(posedge clk); #1;
    send(32'h00000010, 32'h00000020, 1'b1, model(32'h00000010, 32'h00000020, 1'b1));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500us");
    $fatal(1);
  end

endmodule

// File: doc/pipeline_subtractor.md
PIPELINE_SUBTRACTOR -- requirements
Module: pipeline_subtractor

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits, split into 4 byte slices.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  a, b, bi carry an operation this cycle.
REQ-005 in_ready  output  1  block accepts an operation this cycle.
REQ-006 a  input  32  minuend, unsigned/two's-complement.
REQ-007 b  input  32  subtrahend.
REQ-008 bi  input  1  borrow in.
REQ-009 out_valid  output  1  d, bo, ovf hold a completed result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 d  output  32  difference a - b - bi, mod 2^32.
REQ-012 bo  output  1  borrow out; 1 when unsigned a < b + bi.
REQ-013 ovf  output  1  signed overflow of a - b - bi; present only per REQ-027.

Function
REQ-014 The block SHALL be a 4-stage pipeline; stage k (k=1..4) computes byte k-1 of the difference as a + ~b + carry, with carry into byte 0 = ~bi and carry into byte k = carry out of byte k-1 registered in stage k.
REQ-015 Each stage SHALL register its partial difference, its carry, its valid bit and the not-yet-used upper bytes of a and b; no stage SHALL contain more than one 8-bit subtraction.
REQ-016 bo SHALL equal the inverse of the carry out of byte 3.
REQ-017 Advance enable SHALL be en = ~out_valid | out_ready; in_ready SHALL equal en combinationally.
REQ-018 When en=1 all stages SHALL shift by one on the clock edge; when en=0 all stage registers, including outputs, SHALL hold.
REQ-019 An operation SHALL be accepted only on an edge where in_valid=1 and in_ready=1; in_valid=1 with in_ready=0 SHALL NOT be captured.
REQ-020 Without stalls, an operation accepted on edge N SHALL appear with out_valid=1 after edge N+3 (latency 4 edges including capture); throughput 1 per cycle.
REQ-021 Cycles with no accepted operation SHALL enter as bubbles (valid=0) and SHALL never produce out_valid=1.
REQ-022 Results SHALL emerge in acceptance order with no loss or duplication under any out_ready pattern.
REQ-023 out_valid, d, bo, ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Wrap-around: 0x00000000 - 0x00000001 SHALL give d=0xFFFFFFFF, bo=1; no saturation.

Reset
REQ-025 rst_n=0 SHALL immediately, without a clock, clear all stage valid bits, out_valid, d, bo, ovf and all stage data and carry registers to 0.
REQ-026 Operations in flight at reset SHALL be discarded and SHALL never appear after rst_n returns to 1; the first edge with rst_n=1 SHALL accept input normally.

Configuration
REQ-027 With macro PIPE_SUB_OVF_EN defined, ovf SHALL be computed as (a[31] != b[31]) && (d[31] != a[31]), with sign bits of a and b carried down the pipeline to stage 4, and registered with d; without it, ovf SHALL be tied to 0 and no sign-bit registers SHALL be implemented.

Verification
REQ-028 a=5, b=3, bi=0 accepted on edge 0, out_ready=1 -> after edge 3 out_valid=1, d=0x00000002, bo=0, ovf=0.
REQ-029 a=0x01000000, b=1, bi=0 -> d=0x00FFFFFF, bo=0 (borrow across 3 byte slices); a=b=0x12345678, bi=1 -> d=0xFFFFFFFF, bo=1.
REQ-030 a=0x80000000, b=1, bi=0 -> d=0x7FFFFFFF, bo=0, ovf=1 with PIPE_SUB_OVF_EN defined, ovf=0 without.
REQ-031 6 back-to-back ops with out_ready=0 from edge 4 to edge 8 -> in_ready=0 while out_valid=1, output held stable, all 6 results delivered in order after out_ready=1.
REQ-032 3 ops in flight, rst_n pulsed low mid-cycle -> out_valid=0 at once, no result emerges in the following 8 cycles with in_valid=0.
